// File: rtl/icache_ctrl.sv
`timescale 1ns/1ps
// icache_ctrl: direct-mapped 32-line instruction cache controller with 4-beat memory refill and flush-all.
// Hits ack 2 cycles after the request is sampled; misses add the refill; no request is taken while flushing.
module icache_ctrl (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_req,
   input  logic [15:0]  i_req_addr,
   output logic         o_ack,
   output logic [31:0]  o_data,
   input  logic         i_flush,
   output logic         o_busy,
   output logic         o_mem_req,
   output logic [15:0]  o_mem_addr,
   input  logic         i_mem_ack,
   input  logic [31:0]  i_mem_data,
   output logic [4:0]   o_ram_addr,
   output logic [137:0] o_ram_data,
   output logic         o_ram_we,
   input  logic [137:0] i_ram_data
);

   localparam logic [2:0] FLUSH  = 3'd0;
   localparam logic [2:0] IDLE   = 3'd1;
   localparam logic [2:0] LOOKUP = 3'd2;
   localparam logic [2:0] REFILL = 3'd3;
   localparam logic [2:0] WRITE  = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;

   logic [2:0]       state;
   logic [4:0]       flush_cnt;
   logic [1:0]       beat;
   logic             flush_pend;
   logic [8:0]       tag;
   logic [4:0]       index;
   logic [1:0]       word;
   logic [3:0][31:0] line_buf;
   logic [3:0][31:0] ram_words;
   logic             hit;

   assign ram_words = i_ram_data[127:0];
   assign hit       = i_ram_data[137] && (i_ram_data[136:128] == tag);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= FLUSH;
         flush_cnt  <= '0;
         beat       <= '0;
         flush_pend <= 1'b0;
         tag        <= '0;
         index      <= '0;
         word       <= '0;
         line_buf   <= '0;
         o_ack      <= 1'b0;
         o_data     <= '0;
      end else begin
         o_ack <= 1'b0;
         case (state)
            FLUSH: begin
               flush_cnt <= flush_cnt + 5'd1;
               if (flush_cnt == 5'd31)
                  state <= IDLE;
            end
            IDLE: begin
               // o_ack still high means this cycle belongs to the request just answered
               if (flush_pend || i_flush) begin
                  flush_pend <= 1'b0;
                  flush_cnt  <= '0;
                  state      <= FLUSH;
               end else if (i_req && !o_ack) begin
                  tag   <= i_req_addr[15:7];
                  index <= i_req_addr[6:2];
                  word  <= i_req_addr[1:0];
                  state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  o_data <= ram_words[word];
                  o_ack  <= 1'b1;
                  state  <= IDLE;
               end else begin
                  beat  <= '0;
                  state <= REFILL;
               end
            end
            REFILL: begin
               if (i_mem_ack) begin
                  line_buf[beat] <= i_mem_data;
                  beat           <= beat + 2'd1;
                  if (beat == 2'd3)
                     state <= WRITE;
               end
            end
            WRITE: begin
               o_data <= line_buf[word];
               o_ack  <= 1'b1;
               state  <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= FLUSH;
         endcase
         if (i_flush && (state == LOOKUP || state == REFILL || state == WRITE || state == RESP))
            flush_pend <= 1'b1;
      end
   end

   always_comb begin
      o_ram_addr = i_req_addr[6:2];
      o_ram_data = '0;
      o_ram_we   = 1'b0;
      if (state == FLUSH) begin
         o_ram_addr = flush_cnt;
         o_ram_we   = 1'b1;
      end else if (state == WRITE) begin
         o_ram_addr = index;
         o_ram_data = {1'b1, tag, line_buf};
         o_ram_we   = 1'b1;
      end
   end

   assign o_busy     = (state == FLUSH);
   assign o_mem_req  = (state == REFILL);
   assign o_mem_addr = o_mem_req ? {tag, index, beat} : 16'h0000;

endmodule
